inert_intf: RTL and testbench
=============================

INERT_INTF -- requirements
Module: inert_intf

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: one clock; reset is synchronous and active-high.
REQ-003 SHALL have port INT, input, 1, gyro data-ready from sensor; asynchronous to clk.
REQ-004 SHALL have port done, input, 1, one-cycle SPI master transaction-complete pulse.
REQ-005 SHALL have port rd_data, input, 16, SPI master read word; low byte is the register value.
REQ-006 SHALL have port wrt, output, 1, one-cycle pulse that starts an SPI transaction.
REQ-007 SHALL have port cmd, output, 16, SPI command word {addr, data}; feeds SPI master wt_data.
REQ-008 SHALL have port vld, output, 1, one-cycle pulse when yaw_rt is updated.
REQ-009 SHALL have port yaw_rt, output, 16, signed yaw rate {yawH, yawL}.
REQ-010 SHALL have port cal_done, output, 1, offset calibration complete (see Configuration).

Function
REQ-011 SHALL pass INT through a two-flop synchronizer; only the synchronized level (INT_ff2) is used.
REQ-012 SHALL run a 16-bit power-up timer in state INIT_WAIT, advancing to INIT1 when the timer equals 16'hFFFF.
REQ-013 SHALL sequence states INIT_WAIT -> INIT1 (cmd 16'h0D02) -> INIT2 (cmd 16'h1160) -> INIT3 (cmd 16'h1440) -> WAIT_INT -> RD_L (cmd 16'hA600) -> RD_H (cmd 16'hA700) -> WAIT_INT.
REQ-014 SHALL assert wrt for exactly one cycle on entry to each command state, with cmd valid in that cycle and held stable until done.
REQ-015 SHALL leave a command state only on done; no second wrt is issued before the done of the previous one.
REQ-016 SHALL leave WAIT_INT when INT_ff2 is 1; INT high on entry is honoured immediately (level, not edge).
REQ-017 SHALL capture rd_data[7:0] into yawL on done in RD_L and into yawH on done in RD_H.
REQ-018 SHALL update yaw_rt and pulse vld in the cycle after the RD_H done, i.e. 1 cycle latency.
REQ-019 SHALL ignore done when no transaction is outstanding (INIT_WAIT, WAIT_INT).
REQ-020 SHALL ignore INT outside WAIT_INT; an INT that is still high on return to WAIT_INT starts a new read pair.
REQ-021 SHALL hold yaw_rt between updates; vld never asserts during INIT states.

Reset
REQ-022 SHALL on rst force state INIT_WAIT, timer 0, wrt 0, cmd 16'h0000, vld 0, yaw_rt 16'h0000, yawL/yawH 0, synchronizer flops 0.
REQ-023 SHALL on rst mid-transaction abandon it without issuing wrt, and restart the full init sequence.
REQ-024 SHALL ignore a done that arrives in the cycle after reset deassertion.

Configuration
REQ-025 SHALL compile offset calibration in when INERT_CAL_EN is defined.
REQ-026 With INERT_CAL_EN defined, SHALL sum the first 8 raw samples into a 19-bit signed accumulator and compute offset as accumulator >>> 3; vld is suppressed and cal_done is 0 during those 8 samples. Thereafter yaw_rt = raw - offset (16-bit, wrapping) with vld, and cal_done = 1 until rst.
REQ-027 Without INERT_CAL_EN, yaw_rt SHALL equal raw, cal_done SHALL be tied to 1, and no accumulator is synthesized.

Verification
REQ-028 Reset then run 65536 cycles -> wrt pulses with cmd 16'h0D02; after done, 16'h1160; after done, 16'h1440; then no wrt while INT = 0.
REQ-029 Sensor model INT high, reads yawL 8'h8D, yawH 8'h99 -> cmds 16'hA600 then 16'hA700; vld one cycle after second done; yaw_rt = 16'h998D (no CAL).
REQ-030 Second INT with yawL 8'h3D, yawH 8'hCD -> yaw_rt = 16'hCD3D; yaw_rt holds 16'h998D until then.
REQ-031 Stray done pulse in WAIT_INT and INT toggled during RD_L -> no extra wrt; state and yaw_rt unchanged.
REQ-032 rst asserted 3 cycles after wrt in RD_H -> wrt, vld 0, yaw_rt 16'h0000; init sequence restarts after timer.
REQ-033 INERT_CAL_EN, 8 samples of 16'h0010 then 16'h0015 -> no vld and cal_done 0 for the first 8; cal_done 1; 9th vld yaw_rt = 16'h0005.

Source files
------------

// File: rtl/inert_intf.sv
// rtl/inert_intf.sv - gyro interface: power-up init, yaw-rate read pair on INT; optional offset calibration under INERT_CAL_EN
module inert_intf #(
  parameter int TIMER_W = 16  // power-up wait is 2**TIMER_W cycles
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic        vld,
  output logic [15:0] yaw_rt,
  output logic        cal_done
);

  typedef enum logic [2:0] {
    INIT_WAIT, INIT1, INIT2, INIT3, WAIT_INT, RD_L, RD_H
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_int_ff1;
  logic               r_int_ff2;
  logic [TIMER_W-1:0] r_timer;
  logic               r_wrt;
  logic [15:0]        r_cmd;
  logic               w_issue;
  logic [15:0]        w_cmd;
  logic [7:0]         r_yaw_l;
  logic [7:0]         r_yaw_h;
  logic               r_vld;
  logic [15:0]        r_yaw_rt;
  logic [15:0]        w_raw;
  logic               w_rdl_done;
  logic               w_rdh_done;
  logic               w_unused;

  // Raw sample is formed from the high byte arriving now and the low byte captured earlier
  assign w_raw      = {rd_data[7:0], r_yaw_l};
  assign w_rdl_done = (r_state == RD_L) && done;
  assign w_rdh_done = (r_state == RD_H) && done;
  assign w_unused   = ^{rd_data[15:8], r_yaw_h};

  // Two-flop synchronizer for the asynchronous data-ready line
  always_ff @(posedge clk) begin
    if (rst) begin
      r_int_ff1 <= 1'b0;
      r_int_ff2 <= 1'b0;
    end else begin
      r_int_ff1 <= INT;
      r_int_ff2 <= r_int_ff1;
    end
  end

  // Power-up timer runs only while waiting for the sensor to come up
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
    end else if (r_state == INIT_WAIT) begin
      r_timer <= r_timer + {{(TIMER_W-1){1'b0}}, 1'b1};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT_WAIT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state; entering a command state requests a wrt with the command word
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_cmd   = r_cmd;
    case (r_state)
      INIT_WAIT: if (r_timer == '1) begin
        w_next = INIT1; w_issue = 1'b1; w_cmd = 16'h0D02;
      end
      INIT1: if (done) begin
        w_next = INIT2; w_issue = 1'b1; w_cmd = 16'h1160;
      end
      INIT2: if (done) begin
        w_next = INIT3; w_issue = 1'b1; w_cmd = 16'h1440;
      end
      INIT3: if (done) begin
        w_next = WAIT_INT;
      end
      WAIT_INT: if (r_int_ff2) begin
        w_next = RD_L; w_issue = 1'b1; w_cmd = 16'hA600;
      end
      RD_L: if (done) begin
        w_next = RD_H; w_issue = 1'b1; w_cmd = 16'hA700;
      end
      RD_H: if (done) begin
        w_next = WAIT_INT;
      end
      default: w_next = INIT_WAIT;
    endcase
  end

  // wrt is a single-cycle pulse; cmd is held until the next command is issued
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrt <= 1'b0;
      r_cmd <= 16'h0000;
    end else begin
      r_wrt <= w_issue;
      r_cmd <= w_cmd;
    end
  end

  // Capture the register bytes as each read completes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_yaw_l <= 8'h00;
      r_yaw_h <= 8'h00;
    end else begin
      if (w_rdl_done) r_yaw_l <= rd_data[7:0];
      if (w_rdh_done) r_yaw_h <= rd_data[7:0];
    end
  end

`ifdef INERT_CAL_EN
  logic [2:0]  r_cal_cnt;
  logic        r_cal_done;
  logic [18:0] r_acc;
  logic [15:0] r_offset;
  logic [18:0] w_acc_sum;

  assign w_acc_sum = r_acc + {{3{w_raw[15]}}, w_raw};

  // First eight samples build the offset silently, later samples are reported offset-corrected
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld      <= 1'b0;
      r_yaw_rt   <= 16'h0000;
      r_cal_cnt  <= 3'd0;
      r_cal_done <= 1'b0;
      r_acc      <= 19'd0;
      r_offset   <= 16'h0000;
    end else begin
      r_vld <= 1'b0;
      if (w_rdh_done) begin
        if (r_cal_done) begin
          r_vld    <= 1'b1;
          r_yaw_rt <= w_raw - r_offset;
        end else begin
          r_acc     <= w_acc_sum;
          r_cal_cnt <= r_cal_cnt + 3'd1;
          if (r_cal_cnt == 3'd7) begin
            r_offset   <= w_acc_sum[18:3];
            r_cal_done <= 1'b1;
          end
        end
      end
    end
  end

  assign cal_done = r_cal_done;
`else
  // Publish the raw sample one cycle after the high byte arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld    <= 1'b0;
      r_yaw_rt <= 16'h0000;
    end else begin
      r_vld <= w_rdh_done;
      if (w_rdh_done) r_yaw_rt <= w_raw;
    end
  end

  assign cal_done = 1'b1;
`endif

  assign wrt    = r_wrt;
  assign cmd    = r_cmd;
  assign vld    = r_vld;
  assign yaw_rt = r_yaw_rt;

endmodule

// File: tb/tb_inert_intf.sv
// tb/tb_inert_intf.sv - self-checking bench for inert_intf with SPI/sensor responder and transaction-level model
module tb_inert_intf;

  localparam int TW       = 10;
  localparam int INIT_CYC = 1 << TW;
`ifdef INERT_CAL_EN
  localparam bit CAL_RESET = 1'b0;
`else
  localparam bit CAL_RESET = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        INT = 1'b0;
  logic        done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt;
  logic [15:0] cmd;
  logic        vld;
  logic [15:0] yaw_rt;
  logic        cal_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] CMDS [5] = '{16'h0D02, 16'h1160, 16'h1440, 16'hA600, 16'hA700};

  always #5 clk = ~clk;

  inert_intf #(.TIMER_W(TW)) u_dut (
    .clk(clk), .rst(rst), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .vld(vld), .yaw_rt(yaw_rt), .cal_done(cal_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // cycle index counted from the last edge that sampled reset
  bit rst_s = 1'b1;
  int cyc = 0;
  always @(posedge clk) begin
    rst_s = rst;
    cyc   = rst ? 0 : cyc + 1;
  end

  // stimulus controls: main raises request counts, driver consumes them
  int          int_mode = 0;
  int          req_total = 0, req_used = 0;
  int          tog_req = 0, tog_used = 0;
  int          lrh_req = 0, lrh_used = 0;
  int          rdh_cyc = -1;
  logic [15:0] raw_q[$];

  // SPI master / sensor responder
  initial begin : driver
    logic [15:0] pend_cmd;
    logic [15:0] cur_raw;
    int          done_at, tog_from, tog_to;
    bit          outst;
    pend_cmd = 16'h0; cur_raw = 16'h0; done_at = 0; tog_from = -10; tog_to = -10; outst = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      done    = 1'b0;
      rd_data = 16'($urandom);
      if (rst_s) begin
        outst = 1'b0;
        done  = 1'b1;
      end else if (wrt) begin
        outst    = 1'b1;
        pend_cmd = cmd;
        done_at  = cyc + int'($urandom_range(1, 5));
        if (cmd == 16'hA600) begin
          if (int_mode == 3) req_used++;
          if (tog_used < tog_req) begin
            tog_used++; tog_from = cyc + 1; tog_to = cyc + 2; done_at = cyc + 8;
          end
        end
        if (cmd == 16'hA700 && lrh_used < lrh_req) begin
          lrh_used++; done_at = cyc + 6; rdh_cyc = cyc;
        end
      end else if (outst && cyc == done_at) begin
        outst = 1'b0;
        done  = 1'b1;
        if (pend_cmd == 16'hA600) begin
          if (raw_q.size() > 0) cur_raw = raw_q.pop_front();
          else cur_raw = 16'($urandom);
          rd_data[7:0] = cur_raw[7:0];
        end else if (pend_cmd == 16'hA700) begin
          rd_data[7:0] = cur_raw[15:8];
        end
      end else if (!outst && $urandom_range(0, 5) == 0) begin
        done = 1'b1;
      end
      case (int_mode)
        0:       INT = 1'b0;
        2:       if ($urandom_range(0, 7) == 0) INT = ~INT;
        default: INT = (req_used < req_total) || (cyc >= tog_from && cyc <= tog_to);
      endcase
    end
  end

  // behavioural model: expected wrt/cmd/vld/yaw_rt/cal_done per cycle
  int          m_issue_at = INIT_CYC, m_issue_c = 0, m_wait_from = 0, m_vld_at = -1;
  int          m_idx = 0, m_cur = 0;
  bit          m_out = 1'b0, m_wait = 1'b0, m_pend_vld = 1'b0, m_pend_cal = 1'b0, m_cal = CAL_RESET;
  logic [15:0] m_yaw = 16'h0, m_pend_yaw = 16'h0;
  logic [7:0]  m_yl = 8'h0;
  bit          int_hist [4];
`ifdef INERT_CAL_EN
  int          m_ns = 0, m_sum = 0, m_off = 0;
`endif
  int          vld_cnt = 0;
  int          seen_n = 0;
  int          first_wrt_cyc = -1;
  logic [15:0] seen_cmd [64];

  always @(negedge clk) begin : compare
    int          c;
    logic [15:0] raw;
    bit          ew, ev;
    c = cyc;
    if (rst_s) begin
      m_issue_at = INIT_CYC; m_out = 1'b0; m_wait = 1'b0; m_vld_at = -1; m_idx = 0;
      m_yaw = 16'h0; m_cal = CAL_RESET; m_yl = 8'h0;
`ifdef INERT_CAL_EN
      m_ns = 0; m_sum = 0; m_off = 0;
`endif
      check("rst_wrt", wrt, 0);
      check("rst_vld", vld, 0);
      check("rst_yaw", yaw_rt, 0);
      check("rst_cal_done", cal_done, CAL_RESET);
    end else begin
      if (m_wait && c >= m_wait_from && int_hist[(c - 2) & 3]) begin
        m_wait = 1'b0; m_issue_at = c + 1;
      end
      ew = (c == m_issue_at);
      check("wrt", wrt, ew);
      if (ew) begin
        check("cmd", cmd, CMDS[m_idx]);
        m_out = 1'b1; m_issue_c = c; m_cur = m_idx;
      end else if (m_out) begin
        check("cmd_hold", cmd, CMDS[m_cur]);
      end
      if (wrt) begin
        if (seen_n < 64) seen_cmd[seen_n] = cmd;
        if (seen_n == 0) first_wrt_cyc = c;
        seen_n++;
      end
      ev = (c == m_vld_at) && m_pend_vld;
      if (c == m_vld_at) begin
        if (m_pend_vld) m_yaw = m_pend_yaw;
        if (m_pend_cal) m_cal = 1'b1;
      end
      check("vld", vld, ev);
      check("yaw_rt", yaw_rt, m_yaw);
      check("cal_done", cal_done, m_cal);
      if (vld) vld_cnt++;
      if (!rst && done && m_out && c > m_issue_c) begin
        m_out = 1'b0;
        case (m_cur)
          0, 1: begin m_idx = m_cur + 1; m_issue_at = c + 1; end
          2:    begin m_idx = 3; m_wait = 1'b1; m_wait_from = c + 1; end
          3:    begin m_yl = rd_data[7:0]; m_idx = 4; m_issue_at = c + 1; end
          default: begin
            raw = {rd_data[7:0], m_yl};
`ifdef INERT_CAL_EN
            if (m_ns < 8) begin
              m_sum += int'($signed(raw));
              m_ns++;
              m_pend_vld = 1'b0;
              m_pend_cal = (m_ns == 8);
              if (m_ns == 8) m_off = m_sum >>> 3;
            end else begin
              m_pend_vld = 1'b1; m_pend_cal = 1'b0;
              m_pend_yaw = raw - m_off[15:0];
            end
`else
            m_pend_vld = 1'b1; m_pend_cal = 1'b0; m_pend_yaw = raw;
`endif
            m_vld_at = c + 1; m_idx = 3; m_wait = 1'b1; m_wait_from = c + 1;
          end
        endcase
      end
    end
    int_hist[c & 3] = INT;
  end

  task automatic wait_vld(input int n, input int bound);
    for (int i = 0; i < bound && vld_cnt < n; i++) @(negedge clk);
    check("vld_count", vld_cnt, n);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time %0t exceeded limit, finished 0 want 1", $time);
    $fatal(1);
  end

  initial begin : main
    int nb, vb;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // power-up init: exactly three commands, then silence with INT low
    repeat (INIT_CYC + 60) @(posedge clk);
    #2;
    check("init_wrt_count", seen_n, 3);
    check("first_wrt_cycle", first_wrt_cyc, INIT_CYC);
    for (int i = 0; i < 3; i++) check("init_cmd", seen_cmd[i], CMDS[i]);

    int_mode = 3;
`ifdef INERT_CAL_EN
    repeat (8) raw_q.push_back(16'h0010);
    raw_q.push_back(16'h0015);
    req_total += 9;
    wait_vld(1, 600);
    check("cal_yaw_9th", yaw_rt, 16'h0005);
    check("cal_done_after", cal_done, 1);
    repeat (30) @(posedge clk);
    #2 check("cal_wrt_count", seen_n, 21);
`else
    raw_q.push_back(16'h998D);
    req_total += 1;
    wait_vld(1, 200);
    check("yaw_first", yaw_rt, 16'h998D);
    repeat (30) @(posedge clk);
    #2;
    check("yaw_hold", yaw_rt, 16'h998D);
    check("wrt_count_pair1", seen_n, 5);
    check("pair1_cmd_l", seen_cmd[3], 16'hA600);
    check("pair1_cmd_h", seen_cmd[4], 16'hA700);
    raw_q.push_back(16'hCD3D);
    tog_req += 1;
    req_total += 1;
    wait_vld(2, 200);
    check("yaw_second", yaw_rt, 16'hCD3D);
    repeat (30) @(posedge clk);
    #2 check("wrt_count_pair2", seen_n, 7);
`endif

    // reset three cycles after the RD_H wrt, while that read is still outstanding
    vb = vld_cnt;
    lrh_req += 1;
    req_total += 1;
    for (int i = 0; i < 300 && rdh_cyc < 0; i++) @(posedge clk);
    check("rdh_seen", rdh_cyc >= 0, 1);
    for (int i = 0; i < 20 && cyc < rdh_cyc + 3; i++) @(posedge clk);
    #2 rst = 1'b1;
    nb = seen_n;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    check("rst_no_vld", vld_cnt, vb);
    repeat (INIT_CYC + 40) @(posedge clk);
    #2;
    check("restart_wrt_count", seen_n, nb + 3);
    for (int i = 0; i < 3; i++) check("restart_cmd", seen_cmd[nb + i], CMDS[i]);

    // randomized traffic
    vb = vld_cnt;
    int_mode = 2;
    repeat (3000) @(posedge clk);
    int_mode = 0;
    repeat (40) @(posedge clk);
    check("random_reads_seen", vld_cnt > vb, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
